vending_credit_fsm: RTL
=======================

VENDING_CREDIT_FSM -- requirements
Module: vending_credit_fsm

Interface
REQ-001 SHALL have parameter PRICE, default 3, item price in 50-cent units (1..MAX_CREDIT).
REQ-002 SHALL have parameter CREDIT_W, default 4, credit register width in bits.
REQ-003 SHALL have parameter MAX_CREDIT, default 15, highest credit held (<= 2**CREDIT_W-1).
REQ-004 SHALL have parameter DISP_CYCLES, default 4, dispense pulse length in cycles (>=1).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000, inactivity limit in cycles (used only under VEND_TIMEOUT_EN).
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports fifty / dollar / cancel  input  1 each  one-cycle coin strobes (1 and 2 units) and cancel request.
REQ-009 SHALL have port insert  output  1  high while coins are accepted (IDLE, COLLECT).
REQ-010 SHALL have port dispense  output  1  high while vending.
REQ-011 SHALL have port ret  output  1  one pulse per 50-cent unit refunded.
REQ-012 SHALL have port coin_reject  output  1  one-cycle pulse when a presented coin is not credited.
REQ-013 SHALL have port credit  output  CREDIT_W  current credit in 50-cent units.
REQ-014 SHALL have port busy  output  1  high in VEND and CHANGE.

Function
REQ-015 SHALL implement states IDLE, COLLECT, VEND, CHANGE; outputs registered or decoded from registered state only.
REQ-016 Coin value SHALL be fifty*1 + dollar*2; both strobes in one cycle credit 3.
REQ-017 In IDLE/COLLECT, a coin SHALL be credited the next edge unless credit+value > MAX_CREDIT, in which case credit is unchanged and coin_reject pulses the next cycle.
REQ-018 Coins in VEND/CHANGE SHALL be ignored and coin_reject SHALL pulse.
REQ-019 IDLE SHALL move to COLLECT on a credited coin; if post-add credit >= PRICE it SHALL move directly to VEND.
REQ-020 COLLECT SHALL move to VEND when credit >= PRICE, subtracting PRICE from credit on that edge.
REQ-021 cancel in COLLECT SHALL move to CHANGE; cancel SHALL override a same-cycle coin (coin rejected).
REQ-022 cancel in IDLE, VEND, CHANGE SHALL be ignored.
REQ-023 VEND SHALL hold dispense high exactly DISP_CYCLES cycles, then go to CHANGE if credit>0 else IDLE.
REQ-024 CHANGE SHALL assert ret one cycle per unit, decrementing credit each cycle; when credit reaches 0 it SHALL return to IDLE.
REQ-025 Credit arithmetic SHALL never wrap; underflow is unreachable and SHALL be asserted against.

Reset
REQ-026 rst low SHALL immediately force IDLE, credit=0, counters=0, insert=1, dispense=ret=coin_reject=busy=0, including mid-VEND or mid-CHANGE (credit is lost).
REQ-027 Deassertion SHALL be synchronised to clk before the FSM leaves IDLE.

Configuration
REQ-028 With VEND_TIMEOUT_EN defined, COLLECT with no coin for TIMEOUT_CYCLES consecutive cycles SHALL move to CHANGE; any credited coin restarts the count.
REQ-029 Without VEND_TIMEOUT_EN, COLLECT SHALL wait indefinitely and no timeout counter SHALL be synthesised.

Structure
REQ-030 Package vend_pkg SHALL hold the state enum and coin value constants (COIN_FIFTY=1, COIN_DOLLAR=2).
REQ-031 Sub-module vend_cycle_counter (loadable down-counter with zero flag) SHALL time DISP_CYCLES and TIMEOUT_CYCLES.

Verification
REQ-032 PRICE=3: fifty, then dollar -> credit 1, then 0 after VEND entry; dispense 4 cycles; no ret; IDLE.
REQ-033 dollar, dollar -> credit 4, VEND with credit 1, dispense 4 cycles, one ret pulse, IDLE.
REQ-034 fifty then cancel -> CHANGE, one ret pulse, credit 0; same-cycle dollar+cancel -> coin_reject, no credit added.
REQ-035 MAX_CREDIT=3, PRICE=3: dollar with credit 2 -> rejected, coin_reject pulse; coin during VEND -> coin_reject.
REQ-036 rst low during third dispense cycle -> dispense drops immediately, credit 0, IDLE; fifty after release credits 1.
REQ-037 VEND_TIMEOUT_EN, TIMEOUT_CYCLES=10: fifty then idle 10 cycles -> CHANGE, one ret; a coin at cycle 9 restarts the count.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Holds the FSM state encoding, coin unit values and a coin-value helper.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vend_state_e;

  // Coin values in 50-cent units
  localparam int unsigned COIN_FIFTY  = 1;
  localparam int unsigned COIN_DOLLAR = 2;
  localparam int unsigned COIN_W      = 2;

  // Value of the coins presented this cycle; both strobes together give 3
  function automatic logic [COIN_W-1:0] coin_value(input logic fifty, input logic dollar);
    coin_value = (fifty  ? COIN_W'(COIN_FIFTY)  : '0) +
                 (dollar ? COIN_W'(COIN_DOLLAR) : '0);
  endfunction

endpackage

// File: rtl/vend_cycle_counter.sv
// Loadable down-counter with zero flag; times the dispense pulse and,
// when enabled, the collect inactivity timeout.
// Ports: clk, rst_n (async active-low), load/load_val (load has priority),
//        dec (count down, saturating at zero), zero_c (count is zero).
module vend_cycle_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/vending_credit_fsm.sv
// Vending machine credit controller: accepts 50c/1$ coins, vends when credit
// reaches PRICE, refunds remaining credit one unit per cycle.
// Ports: clk, rst (async active-low, deassertion synchronised internally),
//        fifty/dollar/cancel strobes in; insert, dispense, ret, coin_reject,
//        credit, busy out (all registered).
// Build option: define VEND_TIMEOUT_EN to refund credit after TIMEOUT_CYCLES
// cycles without a coin in COLLECT.
module vending_credit_fsm
  import vend_pkg::*;
#(
  parameter int unsigned PRICE          = 3,
  parameter int unsigned CREDIT_W       = 4,
  parameter int unsigned MAX_CREDIT     = 15,
  parameter int unsigned DISP_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifty,
  input  logic                dollar,
  input  logic                cancel,
  output logic                insert,
  output logic                dispense,
  output logic                ret,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

`ifdef VEND_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Counter only grows to cover the timeout when that feature is built
  localparam int unsigned CNT_MAX = (TIMEOUT_EN && (TIMEOUT_CYCLES > DISP_CYCLES)) ?
                                    TIMEOUT_CYCLES : DISP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SUM_W   = CREDIT_W + 2;

  logic                rst_meta, rst_sync;
  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                reject_d, insert_d, dispense_d, ret_d, busy_d;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                coin, fits;
  logic [COIN_W-1:0]   value;
  logic [SUM_W-1:0]    sum, credit_add;

  // Reset synchroniser: asserts immediately, releases two edges later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  // Coin arithmetic, widened so the overflow test itself cannot wrap
  assign coin       = fifty | dollar;
  assign value      = coin_value(fifty, dollar);
  assign sum        = SUM_W'(credit) + SUM_W'(value);
  assign fits       = (sum <= SUM_W'(MAX_CREDIT));
  assign credit_add = (coin && fits) ? sum : SUM_W'(credit);

  vend_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_sync),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero)
  );

  // State, credit and output registers
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state_q     <= ST_IDLE;
      credit      <= '0;
      insert      <= 1'b1;
      dispense    <= 1'b0;
      ret         <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit      <= credit_d;
      insert      <= insert_d;
      dispense    <= dispense_d;
      ret         <= ret_d;
      coin_reject <= reject_d;
      busy        <= busy_d;
    end
  end

  // Next-state, credit and counter control
  always_comb begin
    state_d      = state_q;
    credit_d     = credit;
    reject_d     = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = CNT_W'(DISP_CYCLES - 1);

    case (state_q)
      ST_IDLE: begin
        if (coin) begin
          if (!fits) begin
            reject_d = 1'b1;
          end else if (sum >= SUM_W'(PRICE)) begin
            state_d  = ST_VEND;
            credit_d = CREDIT_W'(sum - SUM_W'(PRICE));
            cnt_load = 1'b1;
          end else begin
            state_d  = ST_COLLECT;
            credit_d = CREDIT_W'(sum);
`ifdef VEND_TIMEOUT_EN
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          // Cancel wins over a same-cycle coin
          state_d  = ST_CHANGE;
          reject_d = coin;
        end else if (credit >= CREDIT_W'(PRICE)) begin
          state_d  = ST_VEND;
          credit_d = CREDIT_W'(credit_add - SUM_W'(PRICE));
          reject_d = coin && !fits;
          cnt_load = 1'b1;
        end else if (coin && fits) begin
          credit_d = CREDIT_W'(sum);
`ifdef VEND_TIMEOUT_EN
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        end else begin
          reject_d = coin;
`ifdef VEND_TIMEOUT_EN
          if (cnt_zero) begin
            state_d = ST_CHANGE;
          end else begin
            cnt_dec = 1'b1;
          end
`endif
        end
      end

      ST_VEND: begin
        reject_d = coin;
        if (cnt_zero) begin
          state_d = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_CHANGE: begin
        // Entered only with credit > 0; one unit refunded per cycle
        reject_d = coin;
        credit_d = credit - CREDIT_W'(1);
        if (credit == CREDIT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    insert_d   = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
    dispense_d = (state_d == ST_VEND);
    ret_d      = (state_d == ST_CHANGE);
    busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // Refund must never decrement an empty credit register
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_sync)
    (state_q == ST_CHANGE) |-> (credit != '0));

endmodule
